lm_sm_sequencer: RTL and testbench

Micro-sequencer for Load-Multiple (LM) and Store-Multiple (SM) in the 16-bit 5-stage pipeline. It sits at the RR stage and watches the instruction held in ID/RR. When that instruction is LM/SM with a non-zero register mask, it freezes upstream stages and issues one single-register micro-op per set mask bit into EX. The datapath forms each address as RA + offset.

---
 rtl/risc_pkg.sv | 27 ++
 rtl/lsb_priority_enc.sv | 26 ++
 rtl/lm_sm_sequencer.sv | 113 +++++++++++
 tb/tb_lm_sm_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared ISA constants for the 16-bit pipeline: LM/SM opcodes, IR field positions
// and the LM/SM sequencer state encoding.
package risc_pkg;

    localparam int NREG  = 8;
    localparam int REG_W = $clog2(NREG);

    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    localparam int IR_OPC_MSB = 15;
    localparam int IR_OPC_LSB = 12;
    localparam int IR_RA_MSB  = 11;
    localparam int IR_RA_LSB  = 9;
    localparam int IR_IMM_MSB = 7;
    localparam int IR_IMM_LSB = 0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEQ  = 1'b1;

    // Per-instruction context captured when a sequence starts.
    typedef struct packed {
        logic [REG_W-1:0] base;
        logic             is_store;
    } seq_ctx_t;

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit, its one-hot
// vector (used to clear it) and a flag for "exactly one bit set".
module lsb_priority_enc
    import risc_pkg::*;
(
    input  logic [NREG-1:0]  mask,
    output logic [REG_W-1:0] index,
    output logic [NREG-1:0]  clear,
    output logic             single_bit
);

    // NOTE: combinational logic uses blocking assignments and assigns a default first, so no latch is inferred.
    always_comb begin
        index = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = REG_W'(i);
            end
        end
    end

    // Two's-complement trick isolates the lowest set bit.
    assign clear      = mask & (~mask + NREG'(1));
    assign single_bit = (mask != '0) && ((mask & (mask - NREG'(1))) == '0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM micro-sequencer at the RR stage: freezes upstream and issues one micro-op per
// set mask bit. Define LM_SM_BASE_WB_EN to append a base write-back micro-op.
module lm_sm_sequencer
    import risc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] id_rr_ir,
    input  logic        id_rr_valid,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        stall_upstream,
    output logic        uop_valid,
    output logic        uop_is_store,
    output logic [2:0]  uop_reg,
    output logic [2:0]  uop_base,
    output logic [2:0]  uop_offset,
    output logic        uop_last,
    output logic        busy
);

    logic [0:0]       state;
    logic [NREG-1:0]  mask_q;
    logic [REG_W-1:0] offset_q;
    seq_ctx_t         ctx_q;

    logic [3:0]       opcode;
    logic [REG_W-1:0] ra;
    logic [NREG-1:0]  imm;
    logic             start;
    logic             is_seq;
    logic             wb_phase;
    logic             last;

    logic [REG_W-1:0] enc_index;
    logic [NREG-1:0]  enc_clear;
    logic             enc_single;

    assign opcode = id_rr_ir[IR_OPC_MSB:IR_OPC_LSB];
    assign ra     = id_rr_ir[IR_RA_MSB:IR_RA_LSB];
    assign imm    = id_rr_ir[IR_IMM_MSB:IR_IMM_LSB];

    lsb_priority_enc u_enc (
        .mask       (mask_q),
        .index      (enc_index),
        .clear      (enc_clear),
        .single_bit (enc_single)
    );

    // An all-zero mask is a NOP and never leaves IDLE.
    assign start  = id_rr_valid & ((opcode == OPC_LM) | (opcode == OPC_SM)) & (imm != '0);
    assign is_seq = (state == ST_SEQ);

`ifdef LM_SM_BASE_WB_EN
    // Once every register bit is consumed, the remaining micro-op is the base write-back.
    // Its offset is the register count; a full mask (8) wraps to 0 in the 3-bit field.
    assign wb_phase = is_seq & (mask_q == '0);
    assign last     = wb_phase;
`else
    assign wb_phase = 1'b0;
    assign last     = is_seq & enc_single;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            mask_q   <= '0;
            offset_q <= '0;
            ctx_q    <= '0;
        end else if (flush) begin
            state    <= ST_IDLE;
            mask_q   <= '0;
            offset_q <= '0;
        end else if (!is_seq) begin
            if (start) begin
                state    <= ST_SEQ;
                mask_q   <= imm;
                offset_q <= '0;
                ctx_q    <= '{base: ra, is_store: (opcode == OPC_SM)};
            end
        end else if (!ex_stall) begin
            mask_q <= mask_q & ~enc_clear;
            if (last) begin
                state    <= ST_IDLE;
                offset_q <= '0;
            end else begin
                offset_q <= offset_q + REG_W'(1);
            end
        end
    end

    // Micro-op fields read as zero whenever no micro-op is presented.
    always_comb begin
        uop_valid    = is_seq;
        uop_is_store = is_seq & ctx_q.is_store;
        uop_base     = is_seq ? ctx_q.base : '0;
        uop_offset   = is_seq ? offset_q : '0;
        uop_last     = last;
        busy         = is_seq;
        uop_reg      = '0;
        if (is_seq) begin
            uop_reg = wb_phase ? ctx_q.base : enc_index;
        end
        // Release one cycle early so the next instruction enters ID/RR as the last micro-op enters EX.
        if (is_seq) begin
            stall_upstream = ~(last & ~ex_stall);
        end else begin
            stall_upstream = start & ~flush;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Randomized self-checking bench for lm_sm_sequencer against a queue-based
// reference model of the micro-op stream (honours LM_SM_BASE_WB_EN).
module tb_lm_sm_sequencer;

    localparam logic [3:0] LM = 4'b0110;
    localparam logic [3:0] SM = 4'b0111;

    typedef struct {
        logic [2:0] r;
        logic [2:0] off;
        bit         last;
    } exp_uop_t;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] id_rr_ir;
    logic        id_rr_valid;
    logic        ex_stall;
    logic        flush;
    logic        stall_upstream;
    logic        uop_valid;
    logic        uop_is_store;
    logic [2:0]  uop_reg;
    logic [2:0]  uop_base;
    logic [2:0]  uop_offset;
    logic        uop_last;
    logic        busy;

    int tests = 0;
    int fails = 0;

    lm_sm_sequencer dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .id_rr_ir       (id_rr_ir),
        .id_rr_valid    (id_rr_valid),
        .ex_stall       (ex_stall),
        .flush          (flush),
        .stall_upstream (stall_upstream),
        .uop_valid      (uop_valid),
        .uop_is_store   (uop_is_store),
        .uop_reg        (uop_reg),
        .uop_base       (uop_base),
        .uop_offset     (uop_offset),
        .uop_last       (uop_last),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_quiet(input string tag);
        check({tag, "_valid"}, uop_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_stall"}, stall_upstream, 0);
    endtask

    // Presents one instruction that must not start a sequence.
    task automatic no_start(input string tag, input logic [15:0] ir, input logic v);
        id_rr_ir    = ir;
        id_rr_valid = v;
        #4;
        expect_quiet(tag);
        next_cycle();
        #4;
        expect_quiet({tag, "_next"});
        id_rr_valid = 1'b0;
        next_cycle();
    endtask

    // Runs one LM/SM instruction. hold_uop/hold_len force a fixed ex_stall burst,
    // abort_at >= 0 aborts on that micro-op by flush (abort_rst=0) or reset (abort_rst=1).
    task automatic run_seq(input bit store, input logic [2:0] ra, input logic [7:0] mask,
                           input int stall_pct, input int hold_uop, input int hold_len,
                           input int abort_at, input bit abort_rst);
        exp_uop_t q[$];
        exp_uop_t u;
        int cnt;
        int n;
        int s;
        int stalls;
        int up_cnt;

        cnt = $countones(mask);
        n   = 0;
        for (int k = 0; k < 8; k++) begin
            if (mask[k]) begin
                u.r   = 3'(k);
                u.off = 3'(n);
`ifdef LM_SM_BASE_WB_EN
                u.last = 1'b0;
`else
                u.last = (n == cnt - 1);
`endif
                q.push_back(u);
                n++;
            end
        end
`ifdef LM_SM_BASE_WB_EN
        if (cnt > 0) begin
            u.r    = ra;
            u.off  = 3'(cnt % 8);
            u.last = 1'b1;
            q.push_back(u);
        end
`endif

        id_rr_ir    = {store ? SM : LM, ra, 1'($urandom_range(1)), mask};
        id_rr_valid = 1'b1;
        ex_stall    = 1'b0;
        flush       = 1'b0;
        #4;
        check("det_stall", stall_upstream, (mask != 0) ? 1 : 0);
        check("det_valid", uop_valid, 0);
        check("det_busy", busy, 0);
        up_cnt = int'(stall_upstream);
        stalls = 0;
        next_cycle();

        for (int i = 0; i < q.size(); i++) begin
            s = 0;
            forever begin
                if (i == abort_at) begin
                    if (abort_rst) begin
                        ex_stall = 1'b0;
                        #2;
                        RST_N       = 1'b0;
                        id_rr_valid = 1'b0;
                        #1;
                        check("rst_outputs", {stall_upstream, uop_valid, uop_is_store, uop_reg,
                                              uop_base, uop_offset, uop_last, busy}, 0);
                        next_cycle();
                        RST_N = 1'b1;
                    end else begin
                        // flush outranks a simultaneous ex_stall
                        flush    = 1'b1;
                        ex_stall = 1'b1;
                        #4;
                        check("flush_cyc_valid", uop_valid, 1);
                        check("flush_cyc_reg", uop_reg, q[i].r);
                        next_cycle();
                        flush       = 1'b0;
                        ex_stall    = 1'b0;
                        id_rr_valid = 1'b0;
                    end
                    for (int c = 0; c < 3; c++) begin
                        #4;
                        expect_quiet("abort_idle");
                        next_cycle();
                    end
                    return;
                end
                ex_stall = ((i == hold_uop) && (s < hold_len)) ||
                           (int'($urandom_range(99)) < stall_pct);
                if (s > 20) ex_stall = 1'b0;
                #4;
                check("uop_valid", uop_valid, 1);
                check("uop_reg", uop_reg, q[i].r);
                check("uop_offset", uop_offset, q[i].off);
                check("uop_base", uop_base, ra);
                check("uop_is_store", uop_is_store, store);
                check("uop_last", uop_last, q[i].last);
                check("uop_busy", busy, 1);
                check("uop_stall", stall_upstream, (q[i].last && !ex_stall) ? 0 : 1);
                up_cnt += int'(stall_upstream);
                next_cycle();
                if (!ex_stall) break;
                s++;
                stalls++;
            end
        end

        id_rr_valid = 1'b0;
        ex_stall    = 1'b0;
        #4;
        expect_quiet("end");
        check("stall_total", up_cnt, q.size() + stalls);
        next_cycle();
    endtask

    initial begin
        logic [7:0]  m;
        logic [3:0]  op;
        RST_N       = 1'b0;
        id_rr_ir    = '0;
        id_rr_valid = 1'b0;
        ex_stall    = 1'b0;
        flush       = 1'b0;
        #2;
        check("reset_outputs", {stall_upstream, uop_valid, uop_is_store, uop_reg,
                                uop_base, uop_offset, uop_last, busy}, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        run_seq(1'b0, 3'd2, 8'b1000_0101, 0, -1, 0, -1, 1'b0);
        run_seq(1'b1, 3'd5, 8'hFF,        0, -1, 0, -1, 1'b0);
        run_seq(1'b0, 3'd1, 8'h00,        0, -1, 0, -1, 1'b0);
        run_seq(1'b1, 3'd4, 8'b0000_0110, 0,  1, 2, -1, 1'b0);
        run_seq(1'b0, 3'd6, 8'hF0,        0, -1, 0,  1, 1'b0);
        run_seq(1'b0, 3'd7, 8'h3C,        0, -1, 0,  2, 1'b1);
        run_seq(1'b0, 3'd3, 8'b0000_0011, 0, -1, 0, -1, 1'b0);

        no_start("lm_bubble", {LM, 3'd2, 1'b0, 8'h5A}, 1'b0);
        for (int t = 0; t < 6; t++) begin
            op = 4'($urandom);
            while (op == LM || op == SM) op = 4'($urandom);
            no_start("other_opc", {op, 12'($urandom)}, 1'b1);
        end

        for (int t = 0; t < 40; t++) begin
            m = 8'($urandom);
            if ($urandom_range(7) == 0) m = 8'h00;
            run_seq(1'($urandom_range(1)), 3'($urandom), m, int'($urandom_range(40)), -1, 0,
                    ($urandom_range(4) == 0) ? int'($urandom_range(7)) : -1,
                    1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
